obuf: RTL and testbench

Output buffer for the CIM datapath: accepts one parallel vector of `fifo_length` elements and serialises it one element per beat onto a valid/ready stream. It is the transmit-side counterpart of the input buffer `ibuf`. Element order is chosen so that feeding the `obuf` stream into `ibuf` (one write per accepted beat) reproduces the original vector index-for-index. Its typical placement is between the crossbar/ADC result registers and the narrow result path back to the host.

---
 rtl/rho_cim_pkg.sv | 13 +
 rtl/obuf.sv | 80 ++++++++
 tb/tb_obuf.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rho_cim_pkg.sv
// Shared definitions for the CIM datapath buffers (obuf / ibuf).
package rho_cim_pkg;

  // Default element width, shared by the input and output buffers.
  localparam int DATATYPE_SIZE = 8;

  // Output-buffer control states.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } obuf_state_t;

endpackage : rho_cim_pkg

// File: rtl/obuf.sv
// Output buffer: parallel-loads one vector and serialises it, highest index
// first, onto a valid/ready stream. A load coinciding with the last beat
// refills the buffer so consecutive vectors stream without a bubble.
module obuf
  import rho_cim_pkg::*;
#(
  parameter int datatype_size = DATATYPE_SIZE,
  parameter int fifo_length   = 5
) (
  input  logic                                   clk,
  input  logic                                   i_rst_n,
  input  logic                                   i_load,
  output logic                                   o_load_ready,
  input  logic [datatype_size-1:0]               i_data [fifo_length],
  output logic                                   o_valid,
  input  logic                                   i_ready,
  output logic [datatype_size-1:0]               o_data,
  output logic                                   o_last,
  output logic [$clog2(fifo_length+1)-1:0]       o_count
);

  localparam int CW = $clog2(fifo_length + 1);

  obuf_state_t              state_q, state_d;
  logic [datatype_size-1:0] buf_q [fifo_length];
  logic [CW-1:0]            count_q;
  logic                     load_fire;
  logic                     beat_fire;

  // Control state register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Handshake outputs and next-state decode; the i_ready -> o_load_ready
  // path is combinational so a new vector can land on the last beat.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would infer a latch.
    state_d      = state_q;
    o_valid      = (state_q == SHIFT);
    o_last       = (count_q == CW'(1));
    o_load_ready = (state_q == IDLE) || (o_last && i_ready);
    load_fire    = i_load && o_load_ready;
    beat_fire    = o_valid && i_ready;

    if (load_fire)               state_d = SHIFT;
    else if (beat_fire && o_last) state_d = IDLE;
  end

  // Shift register: a load overrides the shift; each beat moves elements
  // toward the output end and back-fills with zero so a drained buffer
  // presents o_data = 0.
  // NOTE: the storage is reset because its contents are directly visible on
  // o_data; reset must force that output to zero.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < fifo_length; k++) buf_q[k] <= '0;
    end else if (load_fire) begin
      for (int k = 0; k < fifo_length; k++) buf_q[k] <= i_data[k];
    end else if (beat_fire) begin
      for (int k = fifo_length - 1; k > 0; k--) buf_q[k] <= buf_q[k-1];
      buf_q[0] <= '0;
    end
  end

  // Remaining-element counter, including the element currently presented.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)       count_q <= '0;
    else if (load_fire) count_q <= CW'(fifo_length);
    else if (beat_fire) count_q <= count_q - CW'(1);
  end

  assign o_data  = buf_q[fifo_length-1];
  assign o_count = count_q;

endmodule : obuf

// File: tb/tb_obuf.sv
// Self-checking bench for obuf: directed scenarios followed by random
// traffic, compared each cycle against a queue-based stream model, plus a
// behavioural ibuf loopback that must rebuild every vector index-for-index.
module tb_obuf;

  localparam int DW = 8;
  localparam int FL = 5;

  typedef logic [DW-1:0] vec_t [FL];

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic          i_load;
  logic          o_load_ready;
  vec_t          i_data;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic [2:0]    o_count;

  obuf #(.datatype_size(DW), .fifo_length(FL)) dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_load       (i_load),
    .o_load_ready (o_load_ready),
    .i_data       (i_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_last       (o_last),
    .o_count      (o_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Stream model: elements still to be sent, in transmit order.
  logic [DW-1:0] exp_q[$];
  // Loopback ibuf model fed by observed beats, and the vector it must rebuild.
  logic [DW-1:0] ib [FL];
  vec_t          cur_vec;
  int            beats = 0;
  vec_t          zero_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t mk(input logic [DW-1:0] base, input logic [DW-1:0] stride);
    vec_t v;
    for (int k = 0; k < FL; k++) v[k] = base + DW'(k) * stride;
    return v;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int k = 0; k < FL; k++) v[k] = DW'($urandom);
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},      o_valid,      0);
    check({tag, "_data"},       o_data,       0);
    check({tag, "_last"},       o_last,       0);
    check({tag, "_count"},      o_count,      0);
    check({tag, "_load_ready"}, o_load_ready, 1);
  endtask

  // One clock cycle: drive inputs (called just after a rising edge), check
  // all outputs mid-cycle against the model, then advance the model.
  task automatic step(input logic ld, input logic rdy, input vec_t d);
    int            n;
    logic          exp_rdy;
    logic [DW-1:0] seen;
    i_load  = ld;
    i_ready = rdy;
    i_data  = d;
    @(negedge clk);
    n       = exp_q.size();
    exp_rdy = (n == 0) || (n == 1 && rdy);
    check("valid",      o_valid,      n > 0);
    check("data",       o_data,       (n > 0) ? exp_q[0] : 0);
    check("last",       o_last,       n == 1);
    check("count",      o_count,      n);
    check("load_ready", o_load_ready, exp_rdy);
    seen = o_data;
    @(posedge clk);
    if (n > 0 && rdy) begin
      void'(exp_q.pop_front());
      for (int k = FL - 1; k > 0; k--) ib[k] = ib[k-1];
      ib[0] = seen;
      beats++;
      if (beats == FL)
        for (int k = 0; k < FL; k++) check($sformatf("loop[%0d]", k), ib[k], cur_vec[k]);
    end
    if (ld && exp_rdy) begin
      exp_q.delete();
      for (int k = FL - 1; k >= 0; k--) exp_q.push_back(d[k]);
      cur_vec = d;
      beats   = 0;
    end
    #1;
  endtask

  initial begin
    vec_t v1, va, vb, vc;
    zero_v = '{default: '0};
    v1 = mk(8'h11, 8'h11);
    va = mk(8'h01, 8'h01);
    vb = mk(8'hA1, 8'h01);
    vc = '{default: 8'hFF};
    for (int k = 0; k < FL; k++) ib[k] = '0;

    // Reset with a load request pending: nothing may be captured.
    i_rst_n = 1'b0;
    i_load  = 1'b1;
    i_ready = 1'b1;
    i_data  = vc;
    #2;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge clk);
    i_load  = 1'b0;
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic serialisation with downstream always ready.
    step(1'b1, 1'b1, v1);
    repeat (FL + 1) step(1'b0, 1'b1, zero_v);

    // Stalls: ready pattern 1,0,0,1,0,0,...
    step(1'b1, 1'b1, v1);
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) step(1'b0, (i % 3) == 0, zero_v);
    step(1'b0, 1'b1, zero_v);

    // Back-to-back: B loaded on A's last beat, no bubble.
    step(1'b1, 1'b1, va);
    repeat (FL - 1) step(1'b0, 1'b1, zero_v);
    step(1'b1, 1'b1, vb);
    repeat (FL) step(1'b0, 1'b1, zero_v);
    step(1'b0, 1'b1, zero_v);

    // Load requests while busy (never on the last beat) must be ignored.
    step(1'b1, 1'b1, v1);
    step(1'b1, 1'b0, vc);
    repeat (3) step(1'b1, 1'b1, vc);
    step(1'b1, 1'b0, vc);
    step(1'b0, 1'b1, vc);
    step(1'b0, 1'b1, zero_v);

    // Asynchronous reset after two of five beats.
    step(1'b1, 1'b1, va);
    repeat (2) step(1'b0, 1'b1, zero_v);
    #3;
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    exp_q.delete();
    beats = 0;
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, vb);
    repeat (FL + 1) step(1'b0, 1'b1, zero_v);

    // Random traffic with loopback reconstruction.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, rnd_vec());
    for (int i = 0; i < 4 * FL && exp_q.size() > 0; i++) step(1'b0, 1'b1, zero_v);
    step(1'b0, 1'b1, zero_v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_obuf
